reed_speed_meter: RTL and testbench
===================================

Name: reed_speed_meter

Overview:
- Receive-side counterpart of the reed-contact stimulus. Turns raw reed switch pulses plus the wheel circumference `circ` into instantaneous speed in km/h, a moving flag, and a per-revolution tick.
- Sits between the `reed` input pin and the bicycle computer's distance, trip-time, average and max-speed logic.
- Uses a multi-cycle sequential divider, not a combinational one.

Parameters:
- F_CLK, 2048: clock frequency in Hz.
- MIN_SPEED, 3: km/h below which the bike is declared stopped.
- SYNC_STAGES, 2: reed synchroniser depth (≥1).
- CNT_W, 16: interval counter width.
- SAT_SPEED, 99: speed saturation value.

Ports:
- clock, input, 1: system clock, F_CLK.
- reset_in, input, 1: synchronous, active-high reset.
- reed, input, 1: raw reed contact, asynchronous level.
- circ, input, 8: wheel circumference in cm. Sampled at every accepted edge.
- speed, output, 7: current speed in km/h, 0..SAT_SPEED, held between updates.
- moving, output, 1: high while the wheel is considered turning.
- rev_tick, output, 1: one-cycle pulse per accepted reed rising edge, for the distance accumulator.
- speed_upd, output, 1: one-cycle pulse in the cycle `speed` changes register value source (division done or timeout).
- busy, output, 1: high while the divider is running.

Behaviour:
- Clock and reset: single clock `clock`. Reset is synchronous, active-high on `reset_in`.
- Reset state: speed=0, moving=0, rev_tick=0, speed_upd=0, busy=0, cnt=0, state IDLE, synchroniser flops=0.
- Reset has priority over every event, including mid-division: the division is aborted and no speed_upd is issued.
- Input conditioning: `reed` passes through SYNC_STAGES flops, then a rising-edge detector. The accepted edge cycle E is when rev_tick=1. E comes SYNC_STAGES+1 cycles after reed first samples high.
- Interval counter `cnt`:
  - Cleared to 0 in cycle E.
  - Otherwise increments each cycle while moving=1.
  - Saturates at all-ones.
  - At E the captured interval is P = cnt (edge-to-edge distance minus 1).
- State machine:
  - IDLE: on edge → MEAS, moving=1, cnt=0, speed unchanged, no division.
  - MEAS: on edge → DIV, latching N = circ*F_CLK*36 and D = P*1000.
  - MEAS: on timeout → IDLE, speed=0, moving=0, speed_upd=1.
  - DIV: a restoring divider, 1 quotient bit per cycle, runs 25 iterations in E+1..E+25 with busy=1.
  - DIV result: at E+26, speed = min(quotient, SAT_SPEED), speed_upd=1, state returns to MEAS.
  - Latency from edge to speed is exactly 26 cycles.
- Division rules: quotient is truncated, which matches real-to-integer truncation. If D==0, speed=SAT_SPEED, with no divide-by-zero hazard.
- Width rules: N is at most 255*73728 < 2^25, so N_W=25. D is up to 2^16*1000, so D_W=26.
- Timeout:
  - Condition: cnt*MIN_SPEED*1000 > circ*F_CLK*36. This is a multiply-compare; no divider is used.
  - Evaluated in MEAS and DIV, using the current `circ`.
  - A timeout in DIV aborts the division: speed=0, moving=0, speed_upd=1, state → IDLE.
- Edge during DIV: abort the running division, restart with the new P and circ, and count 26 cycles from the new E. The aborted result is never written.
- Edge and timeout in the same cycle: the edge wins, and the division starts.
- `circ` changes mid-interval: no effect until the next sample point (edge or timeout compare).

Decomposition:
- Package `bicycle_pkg`:
  - F_CLK.
  - KMH_FACTOR=36.
  - SCALE=1000.
  - N_W, D_W.
  - State enum {IDLE, MEAS, DIV}.
  - SAT_SPEED.
- One sub-module `seq_divider`:
  - Ports: start, numerator, denominator, busy, done, quotient.
  - Abort on start while busy.
  - Fixed 25 cycles.
  - Synchronous reset.

Test Plan:
- circ=255, reed edges every 1000 cycles: 1st edge → moving=1, speed=0. 2nd edge: P=999 → speed=18 exactly 26 cycles after rev_tick, speed_upd pulses once.
- circ=255, edges every 200 cycles: P=199 → speed=94. Edges every 100 cycles: P=99 → raw 189 → speed=99, saturated.
- circ=255, stop edges after speed=18: timeout fires at cnt=6267, not 6266 → speed=0, moving=0, speed_upd=1. The next edge re-enters MEAS with speed still 0.
- Two edges 10 cycles apart during DIV: first division aborted, no speed_upd for it. Result from P=9 is saturated 99 at new E+26.
- reset_in asserted at E+12 during DIV: next cycle all outputs 0, state IDLE, no speed_upd. The first subsequent edge gives moving=1 only.
- reed held high for 500 cycles: exactly one rev_tick. Glitch-free across SYNC_STAGES=2; rev_tick comes 3 cycles after reed rises.

Source files
------------

// File: rtl/bicycle_pkg.sv
// Shared constants, widths and FSM encoding for the bicycle computer speed path.
// N_W/D_W are sized for the default clock and an 8-bit circumference.
package bicycle_pkg;

    localparam int F_CLK      = 2048;
    localparam int KMH_FACTOR = 36;
    localparam int SCALE      = 1000;
    localparam int N_W        = 25;
    localparam int D_W        = 26;
    localparam int SAT_SPEED  = 99;
    localparam int SPEED_W    = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        DIV  = 2'd2
    } state_t;

    // circ[cm] * F_CLK * 36: numerator whose quotient by P*1000 is km/h.
    function automatic logic [N_W-1:0] circ_to_num(input logic [7:0] c, input int f_clk);
        return N_W'(c) * N_W'(f_clk * KMH_FACTOR);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle, fixed N_W iterations.
// done is high during the final iteration; quotient is valid in that same cycle.
module seq_divider
    import bicycle_pkg::*;
(
    input  logic           clock,
    input  logic           reset_in,
    input  logic           start,
    input  logic           abort,
    input  logic [N_W-1:0] numerator,
    input  logic [D_W-1:0] denominator,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient
);

    localparam int IT_W = $clog2(N_W);
    localparam logic [IT_W-1:0] LAST = IT_W'(N_W - 1);

    logic [N_W-1:0]  quo_q;
    logic [N_W-1:0]  quo_next;
    logic [D_W-1:0]  rem_q;
    logic [D_W-1:0]  rem_next;
    logic [D_W-1:0]  den_q;
    logic [D_W:0]    rem_shift;
    logic [IT_W-1:0] iter_q;
    logic            fits;

    // When the trial subtract fails the shifted remainder is below den, so its MSB is 0.
    always_comb begin
        rem_shift = {rem_q, quo_q[N_W-1]};
        fits      = (rem_shift >= {1'b0, den_q});
        rem_next  = fits ? D_W'(rem_shift - {1'b0, den_q}) : rem_shift[D_W-1:0];
        quo_next  = {quo_q[N_W-2:0], fits};
    end

    assign done     = busy && (iter_q == LAST);
    assign quotient = quo_next;

    always_ff @(posedge clock) begin
        if (reset_in) begin
            busy   <= 1'b0;
            iter_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            iter_q <= '0;
            quo_q  <= numerator;
            rem_q  <= '0;
            den_q  <= denominator;
        end else if (busy) begin
            quo_q  <= quo_next;
            rem_q  <= rem_next;
            iter_q <= iter_q + IT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reed_speed_meter.sv
// Reed-contact speed meter: synchronises reed pulses, measures the edge-to-edge
// interval and divides circumference by interval into km/h, with stop timeout.
module reed_speed_meter
    import bicycle_pkg::*;
#(
    parameter int F_CLK       = bicycle_pkg::F_CLK,
    parameter int MIN_SPEED   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int SAT_SPEED   = bicycle_pkg::SAT_SPEED
) (
    input  logic               clock,
    input  logic               reset_in,
    input  logic               reed,
    input  logic [7:0]         circ,
    output logic [SPEED_W-1:0] speed,
    output logic               moving,
    output logic               rev_tick,
    output logic               speed_upd,
    output logic               busy,
    output state_t             fsm_state
);

    // Handshake: the divider takes start as a one-cycle strobe, operands
    // sampled with it; done is a one-cycle strobe with quotient valid alongside.

    localparam int TO_W = CNT_W + 14;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   edge_seen;

    state_t         state_q;
    state_t         state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [N_W-1:0] n_now;
    logic [N_W-1:0] num_q;
    logic [D_W-1:0] den_q;
    logic [TO_W-1:0] stop_lhs;
    logic           timeout;
    logic           start_q;
    logic           div_start;
    logic           div_abort;
    logic           go_idle;
    logic           take_result;
    logic           div_done;
    logic [N_W-1:0] div_quotient;

    assign edge_seen = sync_q[SYNC_STAGES-1] & ~sync_prev;

    // Stop test is a multiply-compare against the live circumference.
    assign n_now    = circ_to_num(circ, F_CLK);
    assign stop_lhs = TO_W'(cnt_q) * TO_W'(MIN_SPEED * SCALE);
    assign timeout  = (state_q != IDLE) && (stop_lhs > TO_W'(n_now));

    always_comb begin
        state_d     = state_q;
        div_start   = 1'b0;
        div_abort   = 1'b0;
        go_idle     = 1'b0;
        take_result = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_seen) begin
                    state_d = MEAS;
                end
            end
            MEAS: begin
                if (edge_seen) begin
                    state_d   = DIV;
                    div_start = 1'b1;
                end else if (timeout) begin
                    state_d = IDLE;
                    go_idle = 1'b1;
                end
            end
            DIV: begin
                // A pending restart (start_q) masks a stale done from the aborted run.
                if (edge_seen) begin
                    div_start = 1'b1;
                end else if (timeout) begin
                    state_d   = IDLE;
                    go_idle   = 1'b1;
                    div_abort = 1'b1;
                end else if (div_done && !start_q) begin
                    state_d     = MEAS;
                    take_result = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_in) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q[0] <= reed;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            speed     <= '0;
            moving    <= 1'b0;
            rev_tick  <= 1'b0;
            speed_upd <= 1'b0;
            start_q   <= 1'b0;
            num_q     <= '0;
            den_q     <= '0;
        end else begin
            state_q   <= state_d;
            rev_tick  <= edge_seen;
            start_q   <= div_start;
            speed_upd <= go_idle | take_result;

            if (edge_seen) begin
                cnt_q <= '0;
            end else if (moving && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (edge_seen) begin
                moving <= 1'b1;
            end else if (go_idle) begin
                moving <= 1'b0;
            end

            if (go_idle) begin
                speed <= '0;
            end else if (take_result) begin
                if ((den_q == '0) || (div_quotient > N_W'(SAT_SPEED))) begin
                    speed <= SPEED_W'(SAT_SPEED);
                end else begin
                    speed <= div_quotient[SPEED_W-1:0];
                end
            end

            if (div_start) begin
                num_q <= n_now;
                den_q <= D_W'(cnt_q) * D_W'(SCALE);
            end
        end
    end

    seq_divider u_div (
        .clock       (clock),
        .reset_in    (reset_in),
        .start       (start_q),
        .abort       (div_abort),
        .numerator   (num_q),
        .denominator (den_q),
        .busy        (busy),
        .done        (div_done),
        .quotient    (div_quotient)
    );

    assign fsm_state = state_q;

endmodule

// File: tb/tb_reed_speed_meter.sv
// Directed bench for reed_speed_meter: interval-to-speed results, latency,
// saturation, stop timeout, division abort, mid-division reset, synchroniser.
module tb_reed_speed_meter;
  import bicycle_pkg::*;

  logic       clock;
  logic       reset_in;
  logic       reed;
  logic [7:0] circ;
  logic [6:0] speed;
  logic       moving;
  logic       rev_tick;
  logic       speed_upd;
  logic       busy;
  state_t     fsm_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int upd_cnt = 0;
  int rev_cnt = 0;
  int t_rise = 0;

  reed_speed_meter dut (
    .clock     (clock),
    .reset_in  (reset_in),
    .reed      (reed),
    .circ      (circ),
    .speed     (speed),
    .moving    (moving),
    .rev_tick  (rev_tick),
    .speed_upd (speed_upd),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    if (speed_upd) upd_cnt++;
    if (rev_tick) rev_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  // Raise reed for three cycles; returns at the sample point of the accepted-edge cycle E.
  task automatic launch_edge();
    t_rise = cyc;
    reed = 1'b1;
    repeat (3) @(negedge clock);
    reed = 1'b0;
  endtask

  task automatic launch_at(input int t);
    wait_until(t);
    launch_edge();
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    reed = 1'b0;
    circ = 8'd255;
    repeat (3) @(negedge clock);
    reset_in = 1'b0;
    checks++;
    if (speed !== 7'd0 || moving !== 1'b0 || rev_tick !== 1'b0 || speed_upd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: speed=%0d moving=%b rev=%b upd=%b busy=%b, want all 0", speed, moving, rev_tick, speed_upd, busy);
    end
    checks++;
    if (fsm_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", fsm_state, IDLE);
    end
  endtask

  // reed held high 500 cycles: one tick, 3 cycles after rising, first edge only arms.
  task automatic test_sync_hold();
    int lat;
    int rev0;
    int upd0;
    rev0 = rev_cnt;
    upd0 = upd_cnt;
    t_rise = cyc;
    reed = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (rev_tick === 1'b1 && lat == 0) lat = k;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL sync_latency: got %0d cycles want 3", lat);
    end
    checks++;
    if (moving !== 1'b1 || speed !== 7'd0 || fsm_state !== MEAS) begin
      errors++;
      $display("FAIL first_edge: moving=%b speed=%0d state=%0d, want 1 0 %0d", moving, speed, fsm_state, MEAS);
    end
    repeat (490) @(negedge clock);
    reed = 1'b0;
    checks++;
    if (rev_cnt - rev0 != 1) begin
      errors++;
      $display("FAIL hold_one_tick: got %0d ticks want 1", rev_cnt - rev0);
    end
    checks++;
    if (upd_cnt - upd0 != 0) begin
      errors++;
      $display("FAIL first_edge_no_upd: got %0d updates want 0", upd_cnt - upd0);
    end
  endtask

  // One measured interval: check E, E+1, E+25 and E+26 around the result.
  task automatic test_speed(input int period, input logic [6:0] old_spd, input logic [6:0] new_spd);
    int upd0;
    launch_at(t_rise + period);
    upd0 = upd_cnt;
    checks++;
    if (rev_tick !== 1'b1 || busy !== 1'b0 || fsm_state !== DIV) begin
      errors++;
      $display("FAIL p%0d_edge: rev=%b busy=%b state=%0d, want 1 0 %0d", period, rev_tick, busy, fsm_state, DIV);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL p%0d_busy_e1: got %b want 1", period, busy);
    end
    repeat (24) @(negedge clock);
    checks++;
    if (speed !== old_spd || speed_upd !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL p%0d_e25: speed=%0d upd=%b busy=%b, want %0d 0 1", period, speed, speed_upd, busy, old_spd);
    end
    @(negedge clock);
    checks++;
    if (speed !== new_spd || speed_upd !== 1'b1 || busy !== 1'b0 || fsm_state !== MEAS) begin
      errors++;
      $display("FAIL p%0d_e26: speed=%0d upd=%b busy=%b state=%0d, want %0d 1 0 %0d", period, speed, speed_upd, busy, fsm_state, new_spd, MEAS);
    end
    @(negedge clock);
    checks++;
    if (speed_upd !== 1'b0 || upd_cnt - upd0 != 1 || speed !== new_spd) begin
      errors++;
      $display("FAIL p%0d_one_upd: upd=%b count=%0d speed=%0d, want 0 1 %0d", period, speed_upd, upd_cnt - upd0, speed, new_spd);
    end
  endtask

  // 255*73728 / 3000 = 6266.88, so stop fires when cnt reaches 6267.
  task automatic test_timeout();
    wait_until(t_rise + 3 + 6267);
    checks++;
    if (moving !== 1'b1 || speed !== 7'd99 || speed_upd !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cnt6267: moving=%b speed=%0d upd=%b, want 1 99 0", moving, speed, speed_upd);
    end
    @(negedge clock);
    checks++;
    if (moving !== 1'b0 || speed !== 7'd0 || speed_upd !== 1'b1 || fsm_state !== IDLE) begin
      errors++;
      $display("FAIL timeout_fire: moving=%b speed=%0d upd=%b state=%0d, want 0 0 1 %0d", moving, speed, speed_upd, fsm_state, IDLE);
    end
    repeat (20) @(negedge clock);
    launch_edge();
    checks++;
    if (moving !== 1'b1 || speed !== 7'd0 || fsm_state !== MEAS || rev_tick !== 1'b1) begin
      errors++;
      $display("FAIL reenter_meas: moving=%b speed=%0d state=%0d rev=%b, want 1 0 %0d 1", moving, speed, fsm_state, rev_tick, MEAS);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reenter_no_div: busy=%b want 0", busy);
    end
  endtask

  // Edge at 300 starts a division; an edge 10 later aborts it, P=9 saturates.
  task automatic test_back_to_back();
    int upd0;
    launch_at(t_rise + 300);
    upd0 = upd_cnt;
    launch_at(t_rise + 10);
    checks++;
    if (rev_tick !== 1'b1 || busy !== 1'b1 || fsm_state !== DIV) begin
      errors++;
      $display("FAIL b2b_edge: rev=%b busy=%b state=%0d, want 1 1 %0d", rev_tick, busy, fsm_state, DIV);
    end
    repeat (25) @(negedge clock);
    checks++;
    if (speed !== 7'd0 || upd_cnt - upd0 != 0) begin
      errors++;
      $display("FAIL b2b_aborted: speed=%0d updates=%0d, want 0 0", speed, upd_cnt - upd0);
    end
    @(negedge clock);
    checks++;
    if (speed !== 7'd99 || speed_upd !== 1'b1 || upd_cnt - upd0 != 1) begin
      errors++;
      $display("FAIL b2b_result: speed=%0d upd=%b updates=%0d, want 99 1 1", speed, speed_upd, upd_cnt - upd0);
    end
  endtask

  task automatic test_reset_mid_div();
    int upd0;
    launch_at(t_rise + 500);
    upd0 = upd_cnt;
    repeat (12) @(negedge clock);
    reset_in = 1'b1;
    @(negedge clock);
    reset_in = 1'b0;
    checks++;
    if (speed !== 7'd0 || moving !== 1'b0 || rev_tick !== 1'b0 || speed_upd !== 1'b0 || busy !== 1'b0 || fsm_state !== IDLE) begin
      errors++;
      $display("FAIL mid_reset: speed=%0d moving=%b rev=%b upd=%b busy=%b state=%0d, want all 0/IDLE", speed, moving, rev_tick, speed_upd, busy, fsm_state);
    end
    repeat (20) @(negedge clock);
    checks++;
    if (upd_cnt - upd0 != 0 || speed !== 7'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_upd: updates=%0d speed=%0d busy=%b, want 0 0 0", upd_cnt - upd0, speed, busy);
    end
    launch_edge();
    checks++;
    if (moving !== 1'b1 || speed !== 7'd0 || fsm_state !== MEAS) begin
      errors++;
      $display("FAIL post_reset_edge: moving=%b speed=%0d state=%0d, want 1 0 %0d", moving, speed, fsm_state, MEAS);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_no_div: busy=%b want 0", busy);
    end
  endtask

  initial begin
    reset_in = 1'b1;
    reed = 1'b0;
    circ = 8'd255;
    @(negedge clock);
    test_reset();
    test_sync_hold();
    // circ=255: N=18800640; P=999 -> 18, P=199 -> 94, P=99 -> 189 saturates to 99
    test_speed(1000, 7'd0, 7'd18);
    test_speed(200, 7'd18, 7'd94);
    test_speed(100, 7'd94, 7'd99);
    test_timeout();
    test_back_to_back();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
